// File: rtl/play_ctrl.sv
// play_ctrl: umpire-event sequencer keeping ball/strike/out/inning counts and driving the base-runner block.
// Optional build macro PLAY_CTRL_EDGE_EN: event inputs are raw button levels, edge-detected internally.
module play_ctrl #(
  parameter int unsigned NUM_INNINGS = 9,
  parameter int unsigned BALLS_WALK  = 4,
  parameter int unsigned STRIKES_OUT = 3,
  parameter int unsigned OUTS_INNING = 3,
  parameter int unsigned CLR_CYCLES  = 2
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iNEW_GAME,
  input  logic       iBALL,
  input  logic       iSTRIKE,
  input  logic       iHIT,
  input  logic       iOUT,
  output logic       oBASE_ADV,
  output logic       oBASE_KEEP,
  output logic [2:0] oBALL,
  output logic [1:0] oSTRIKE,
  output logic [1:0] oOUT,
  output logic [3:0] oINNING,
  output logic       oHALF,
  output logic       oBUSY,
  output logic       oGAME_OVER
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADV, ST_CLR, ST_OVER} state_t;

  localparam logic [2:0] LP_BALL_LAST   = 3'(BALLS_WALK - 1);
  localparam logic [1:0] LP_STRIKE_LAST = 2'(STRIKES_OUT - 1);
  localparam logic [1:0] LP_OUT_LAST    = 2'(OUTS_INNING - 1);
  localparam logic [1:0] LP_OUTS        = 2'(OUTS_INNING);
  localparam logic [3:0] LP_INNINGS     = 4'(NUM_INNINGS);
  localparam logic [3:0] LP_CLR_LAST    = 4'(CLR_CYCLES - 1);

  state_t     r_state, w_state_nx;
  logic [3:0] r_clr_cnt, w_clr_nx;
  logic [2:0] r_ball, w_ball_nx;
  logic [1:0] r_strike, w_strike_nx;
  logic [1:0] r_out, w_out_nx;
  logic [3:0] r_inning, w_inning_nx;
  logic       r_half, w_half_nx;
  logic       r_adv, r_keep, r_busy, r_over;
  logic [3:0] w_evt;  // {out, hit, strike, ball}

`ifdef PLAY_CTRL_EDGE_EN
  logic [3:0] r_evt_q, r_evt_d;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_evt_q <= '0;
      r_evt_d <= '0;
    end else begin
      r_evt_q <= {iOUT, iHIT, iSTRIKE, iBALL};
      r_evt_d <= r_evt_q;
    end
  end

  assign w_evt = r_evt_q & ~r_evt_d;
`else
  assign w_evt = {iOUT, iHIT, iSTRIKE, iBALL};
`endif

  always_comb begin
    w_state_nx  = r_state;
    w_clr_nx    = r_clr_cnt;
    w_ball_nx   = r_ball;
    w_strike_nx = r_strike;
    w_out_nx    = r_out;
    w_inning_nx = r_inning;
    w_half_nx   = r_half;
    case (r_state)
      ST_IDLE: begin
        // A strike that completes the count is handled as an out; a same-cycle hit still wins.
        if (w_evt[3] || (w_evt[1] && !w_evt[2] && r_strike == LP_STRIKE_LAST)) begin
          w_ball_nx   = '0;
          w_strike_nx = '0;
          if (r_out == LP_OUT_LAST) begin
            w_out_nx   = LP_OUTS;
            w_clr_nx   = LP_CLR_LAST;
            w_state_nx = ST_CLR;
          end else begin
            w_out_nx = r_out + 2'd1;
          end
        end else if (w_evt[2]) begin
          w_ball_nx   = '0;
          w_strike_nx = '0;
          w_state_nx  = ST_ADV;
        end else if (w_evt[1]) begin
          w_strike_nx = r_strike + 2'd1;
        end else if (w_evt[0]) begin
          if (r_ball == LP_BALL_LAST) begin
            w_ball_nx   = '0;
            w_strike_nx = '0;
            w_state_nx  = ST_ADV;
          end else begin
            w_ball_nx = r_ball + 3'd1;
          end
        end
      end
      ST_ADV: w_state_nx = ST_IDLE;
      ST_CLR: begin
        if (r_clr_cnt == '0) begin
          w_ball_nx   = '0;
          w_strike_nx = '0;
          w_out_nx    = '0;
          if (r_half && r_inning == LP_INNINGS) begin
            w_state_nx = ST_OVER;
          end else begin
            w_half_nx  = ~r_half;
            w_state_nx = ST_IDLE;
            if (r_half) w_inning_nx = r_inning + 4'd1;
          end
        end else begin
          w_clr_nx = r_clr_cnt - 4'd1;
        end
      end
      ST_OVER: w_state_nx = ST_OVER;
      default: w_state_nx = ST_IDLE;
    endcase
    if (iNEW_GAME) begin
      w_state_nx  = ST_IDLE;
      w_clr_nx    = '0;
      w_ball_nx   = '0;
      w_strike_nx = '0;
      w_out_nx    = '0;
      w_inning_nx = 4'd1;
      w_half_nx   = 1'b0;
    end
  end

  // Status outputs are decoded from the next state so they are registered alongside it.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state   <= ST_IDLE;
      r_clr_cnt <= '0;
      r_ball    <= '0;
      r_strike  <= '0;
      r_out     <= '0;
      r_inning  <= 4'd1;
      r_half    <= 1'b0;
      r_adv     <= 1'b0;
      r_keep    <= 1'b1;
      r_busy    <= 1'b0;
      r_over    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_clr_cnt <= w_clr_nx;
      r_ball    <= w_ball_nx;
      r_strike  <= w_strike_nx;
      r_out     <= w_out_nx;
      r_inning  <= w_inning_nx;
      r_half    <= w_half_nx;
      r_adv     <= (w_state_nx == ST_ADV);
      r_keep    <= !(w_state_nx == ST_CLR || w_state_nx == ST_OVER);
      r_busy    <= (w_state_nx != ST_IDLE);
      r_over    <= (w_state_nx == ST_OVER);
    end
  end

  assign oBASE_ADV  = r_adv;
  assign oBASE_KEEP = r_keep;
  assign oBALL      = r_ball;
  assign oSTRIKE    = r_strike;
  assign oOUT       = r_out;
  assign oINNING    = r_inning;
  assign oHALF      = r_half;
  assign oBUSY      = r_busy;
  assign oGAME_OVER = r_over;

endmodule
